game_sequencer: RTL and testbench

Frame-level game controller for the obstacle-dodging game. It sequences the round through idle, play, dying and game-over states. It latches the per-pixel `crash` flag from the color mapper across each frame and drives the sprite-select inputs (`alternator`, `burn`) back into the color mapper. It also issues flap, motion-enable and restart controls to the ball and obstacle movers, and keeps a BCD score and high score.

---
 rtl/game_sequencer.sv | 163 ++++++++++++++++
 tb/tb_game_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Frame-level round controller: sequences idle/play/dying/over, latches crashes per frame,
// drives sprite selects and mover controls, and keeps a BCD score and high score.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for first flap, wings animate, nothing moves
// PLAY  | round running, flaps kick the ball, passes score
// DYING | burn sprite shown, ball keeps falling for DEATH_FRAMES
// OVER  | round finished, next press restarts to IDLE
module game_sequencer #(
    parameter int unsigned FLAP_PERIOD  = 8,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter logic [9:0]  BALL_X       = 10'd160
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       crash,
    input  logic       flap_key,
    input  logic [9:0] obstacle_x,
    output logic [1:0] state,
    output logic       alternator,
    output logic       burn,
    output logic       motion_en,
    output logic       flap_pulse,
    output logic       restart,
    output logic [7:0] score,
    output logic [7:0] hi_score
);

    localparam int AW = (FLAP_PERIOD > 1) ? $clog2(FLAP_PERIOD) : 1;
    localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam logic [AW-1:0] ANIM_LAST  = AW'(FLAP_PERIOD - 1);
    localparam logic [DW-1:0] DEATH_LOAD = DW'(DEATH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t          cur;
    logic [2:0]      frame_sync;
    logic            key_d;
    logic            crash_seen;
    logic [9:0]      obstacle_prev;
    logic [AW-1:0]   anim_cnt;
    logic [DW-1:0]   death_cnt;

    logic frame_tick, press, crash_hit, pass, anim_wrap;

    assign frame_tick = frame_sync[1] & ~frame_sync[2];
    assign press      = flap_key & ~key_d;
    assign crash_hit  = crash_seen | crash;
    assign pass       = (obstacle_prev >= BALL_X) && (obstacle_x < BALL_X);
    assign anim_wrap  = (anim_cnt == ANIM_LAST);
    assign state      = cur;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync <= '0;
            key_d      <= 1'b0;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
            key_d      <= flap_key;
        end
    end

    // Crash pulses can be narrower than a frame; hold them until the frame decision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            crash_seen <= 1'b0;
        else if (frame_tick)
            crash_seen <= 1'b0;
        else if (crash && cur == S_PLAY)
            crash_seen <= 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur           <= S_IDLE;
            alternator    <= 1'b0;
            burn          <= 1'b0;
            motion_en     <= 1'b0;
            flap_pulse    <= 1'b0;
            restart       <= 1'b0;
            score         <= '0;
            hi_score      <= '0;
            obstacle_prev <= '0;
            anim_cnt      <= '0;
            death_cnt     <= '0;
        end else begin
            flap_pulse <= 1'b0;
            restart    <= 1'b0;

            // Wing animation runs in IDLE and PLAY; the crash branch below overrides it.
            if (frame_tick && (cur == S_IDLE || cur == S_PLAY)) begin
                anim_cnt <= anim_wrap ? '0 : anim_cnt + AW'(1);
                if (anim_wrap)
                    alternator <= ~alternator;
            end

            case (cur)
                S_IDLE: begin
                    if (press) begin
                        cur           <= S_PLAY;
                        motion_en     <= 1'b1;
                        flap_pulse    <= 1'b1;
                        obstacle_prev <= '0;
                    end
                end
                S_PLAY: begin
                    if (frame_tick && crash_hit) begin
                        cur        <= S_DYING;
                        death_cnt  <= DEATH_LOAD;
                        alternator <= 1'b0;
                        anim_cnt   <= '0;
                        burn       <= 1'b1;
                    end else begin
                        if (press)
                            flap_pulse <= 1'b1;
                        if (frame_tick) begin
                            obstacle_prev <= obstacle_x;
                            if (pass)
                                score <= bcd_inc(score);
                        end
                    end
                end
                S_DYING: begin
                    if (frame_tick) begin
                        if (death_cnt == '0) begin
                            cur       <= S_OVER;
                            motion_en <= 1'b0;
                            if (score > hi_score)
                                hi_score <= score;
                        end else begin
                            death_cnt <= death_cnt - DW'(1);
                        end
                    end
                end
                S_OVER: begin
                    if (press) begin
                        cur     <= S_IDLE;
                        burn    <= 1'b0;
                        restart <= 1'b1;
                        score   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer: frames and key presses drive an event-level model
// of the round (integer score, tick counts) that predicts every visible output.
module tb_game_sequencer;

    localparam int FLAP  = 8;
    localparam int DEATH = 60;
    localparam int BALL  = 160;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       crash = 1'b0;
    logic       flap_key = 1'b0;
    logic [9:0] obstacle_x = '0;
    logic [1:0] state;
    logic       alternator, burn, motion_en, flap_pulse, restart;
    logic [7:0] score, hi_score;

    game_sequencer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .crash      (crash),
        .flap_key   (flap_key),
        .obstacle_x (obstacle_x),
        .state      (state),
        .alternator (alternator),
        .burn       (burn),
        .motion_en  (motion_en),
        .flap_pulse (flap_pulse),
        .restart    (restart),
        .score      (score),
        .hi_score   (hi_score)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int flap_seen = 0;
    int restart_seen = 0;

    always @(negedge Clk) begin
        if (flap_pulse === 1'b1) flap_seen++;
        if (restart === 1'b1) restart_seen++;
    end

    // Round model: state number, decimal score, ticks since animation restart, ticks in DYING.
    int m_state, m_score, m_hi, m_prev, m_anim, m_dying;
    bit m_pending;
    int e_flap, e_restart;

    function automatic void model_reset();
        m_state = 0; m_score = 0; m_hi = 0; m_prev = 0;
        m_anim = 0; m_dying = 0; m_pending = 0;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [20:0] exp_vec();
        logic alt;
        alt = (m_state < 2) ? 1'((m_anim / FLAP) % 2) : 1'b0;
        return {2'(m_state), alt, 1'(m_state >= 2), 1'(m_state == 1 || m_state == 2),
                to_bcd(m_score), to_bcd(m_hi)};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {state, alternator, burn, motion_en, score, hi_score};
    endfunction

    function automatic void model_tick(input int ox, input bit cp, input bit key);
        e_flap = 0; e_restart = 0;
        case (m_state)
            0: begin
                m_anim++;
                if (key) begin m_state = 1; e_flap = 1; m_prev = 0; end
            end
            1: begin
                if (m_pending) begin
                    m_state = 2; m_dying = 0; m_anim = 0;
                end else begin
                    if (m_prev >= BALL && ox < BALL && m_score < 99) m_score++;
                    m_prev = ox;
                    m_anim++;
                    if (key) e_flap = 1;
                end
            end
            2: begin
                m_dying++;
                if (m_dying == DEATH) begin
                    m_state = 3;
                    if (m_score > m_hi) m_hi = m_score;
                end
            end
            default: if (key) begin m_state = 0; e_restart = 1; m_score = 0; end
        endcase
        m_pending = cp && (m_state == 1);
    endfunction

    function automatic void model_press(input bit cf);
        e_flap = 0; e_restart = 0;
        case (m_state)
            0: begin m_state = 1; e_flap = 1; m_prev = 0; end
            1: begin e_flap = 1; if (cf) m_pending = 1; end
            2: ;
            default: begin m_state = 0; e_restart = 1; m_score = 0; end
        endcase
    endfunction

    // One frame: frame_clk edge, optional key press landing on the tick cycle,
    // optional single-cycle crash after the tick (counts toward the next tick).
    task automatic do_frame(input int ox, input bit cp, input bit key,
                            output int fl, output int rs);
        int f0, r0;
        f0 = flap_seen; r0 = restart_seen;
        @(negedge Clk); obstacle_x = 10'(ox); frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        if (key) flap_key = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0; flap_key = 1'b0;
        repeat (4) @(negedge Clk);
        if (cp) begin crash = 1'b1; @(negedge Clk); crash = 1'b0; end
        repeat (4) @(negedge Clk);
        fl = flap_seen - f0; rs = restart_seen - r0;
        model_tick(ox, cp, key);
    endtask

    task automatic do_press(input int hold, input bit cf, output int fl, output int rs);
        int f0, r0;
        f0 = flap_seen; r0 = restart_seen;
        @(negedge Clk); flap_key = 1'b1; crash = cf;
        @(negedge Clk); crash = 1'b0;
        repeat (hold - 1) @(negedge Clk);
        flap_key = 1'b0;
        repeat (3) @(negedge Clk);
        fl = flap_seen - f0; rs = restart_seen - r0;
        model_press(cf);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge Clk);
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        if ({flap_pulse, restart} !== 2'b00) begin
            bad++; $display("FAIL reset_pulses: got %b want 00", {flap_pulse, restart});
        end
        total++;
    endtask

    task automatic test_idle();
        int fl, rs;
        for (int i = 0; i < 20; i++) begin
            do_frame(int'($urandom_range(0, 639)), 1'($urandom_range(0, 1)), 1'b0, fl, rs);
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL idle_frame%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            total++;
            if (motion_en !== 1'b0) begin
                bad++; $display("FAIL idle_motion%0d: got %b want 0", i, motion_en);
            end
            total++;
        end
    endtask

    task automatic test_start_flap();
        int fl, rs;
        do_press(10, 1'b1, fl, rs);
        if (fl !== e_flap || fl !== 1) begin
            bad++; $display("FAIL start_flap_count: got %0d want 1", fl);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_state: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        for (int i = 0; i < 2; i++) begin
            do_frame(300, 1'b0, 1'b0, fl, rs);
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL start_settle%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            total++;
        end
        do_press(3, 1'b0, fl, rs);
        if (fl !== 1) begin
            bad++; $display("FAIL second_flap_count: got %0d want 1", fl);
        end
        total++;
    endtask

    task automatic test_scoring();
        int fl, rs;
        int seq[6] = '{160, 159, 159, 160, 160, 0};
        for (int i = 0; i < 12; i++) begin
            do_frame(170, 1'b0, 1'b0, fl, rs);
            do_frame(150, 1'b0, 1'b0, fl, rs);
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL score_pass%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            total++;
        end
        if (score !== 8'h12) begin
            bad++; $display("FAIL score_twelve: got %h want 12", score);
        end
        total++;
        foreach (seq[i]) begin
            do_frame(seq[i], 1'b0, 1'b0, fl, rs);
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL score_edge%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            total++;
        end
        while (m_score < 99) begin
            do_frame(int'($urandom_range(BALL, 639)), 1'b0, 1'($urandom_range(0, 1)), fl, rs);
            do_frame(int'($urandom_range(0, BALL - 1)), 1'b0, 1'b0, fl, rs);
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL score_run: got %h want %h", obs_vec(), exp_vec());
            end
            total++;
        end
        do_frame(500, 1'b0, 1'b0, fl, rs);
        do_frame(10, 1'b0, 1'b0, fl, rs);
        if (score !== 8'h99) begin
            bad++; $display("FAIL score_saturate: got %h want 99", score);
        end
        total++;
    endtask

    task automatic test_crash();
        int fl, rs;
        do_frame(400, 1'b0, 1'b0, fl, rs);
        do_frame(300, 1'b1, 1'b0, fl, rs);
        do_frame(100, 1'b0, 1'b0, fl, rs);
        if (obs_vec() !== exp_vec() || state !== 2'd2) begin
            bad++; $display("FAIL crash_enter: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        for (int i = 1; i <= DEATH; i++) begin
            do_frame(int'($urandom_range(0, 639)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), fl, rs);
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL dying_tick%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            total++;
            if (fl !== 0) begin
                bad++; $display("FAIL dying_flap%0d: got %0d want 0", i, fl);
            end
            total++;
        end
        if (state !== 2'd3 || hi_score !== 8'h99) begin
            bad++; $display("FAIL over_hi: got state %0d hi %h want 3 99", state, hi_score);
        end
        total++;
    endtask

    task automatic test_restart();
        int fl, rs;
        do_press(2, 1'b0, fl, rs);
        if (rs !== 1 || fl !== 0) begin
            bad++; $display("FAIL restart_pulses: got restart %0d flap %0d want 1 0", rs, fl);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL restart_state: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
    endtask

    task automatic test_crash_and_pass();
        int fl, rs;
        do_press(1, 1'b0, fl, rs);
        for (int i = 0; i < 2; i++) begin
            do_frame(200, 1'b0, 1'b0, fl, rs);
            do_frame(100, 1'b0, 1'b0, fl, rs);
        end
        do_frame(200, 1'b1, 1'b0, fl, rs);
        do_frame(100, 1'b0, 1'b1, fl, rs);
        if (obs_vec() !== exp_vec() || score !== 8'h02) begin
            bad++; $display("FAIL crash_pass: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        if (fl !== 0) begin
            bad++; $display("FAIL crash_tick_flap: got %0d want 0", fl);
        end
        total++;
        for (int i = 0; i < DEATH; i++) do_frame(300, 1'b0, 1'b0, fl, rs);
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL low_score_over: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        do_frame(300, 1'b0, 1'b1, fl, rs);
        if (rs !== e_restart || rs !== 1 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL over_tick_press: got rs %0d %h want 1 %h", rs, obs_vec(), exp_vec());
        end
        total++;
        do_frame(300, 1'b0, 1'b1, fl, rs);
        if (fl !== 1 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL idle_tick_press: got fl %0d %h want 1 %h", fl, obs_vec(), exp_vec());
        end
        total++;
        do_frame(250, 1'b0, 1'b1, fl, rs);
        if (fl !== 1 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL play_tick_press: got fl %0d %h want 1 %h", fl, obs_vec(), exp_vec());
        end
        total++;
    endtask

    task automatic test_reset_mid_dying();
        int fl, rs;
        do_frame(300, 1'b1, 1'b0, fl, rs);
        for (int i = 0; i < 5; i++) do_frame(300, 1'b0, 1'b0, fl, rs);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        if ({state, alternator, burn, motion_en, flap_pulse, restart, score, hi_score} !== '0) begin
            bad++; $display("FAIL reset_dying: got %h want 0",
                            {state, alternator, burn, motion_en, flap_pulse, restart, score, hi_score});
        end
        total++;
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge Clk);
        do_press(1, 1'b0, fl, rs);
        for (int i = 0; i < 3; i++) begin
            do_frame(int'($urandom_range(BALL, 639)), 1'b0, 1'b0, fl, rs);
            do_frame(int'($urandom_range(0, BALL - 1)), 1'b0, 1'b0, fl, rs);
        end
        do_frame(300, 1'b1, 1'b0, fl, rs);
        for (int i = 0; i <= DEATH; i++) do_frame(300, 1'b0, 1'b0, fl, rs);
        if (hi_score !== 8'h03 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL hi_after_reset: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
    endtask

    initial begin
        model_reset();
        e_flap = 0; e_restart = 0;
        test_reset();
        test_idle();
        test_start_flap();
        test_scoring();
        test_crash();
        test_restart();
        test_crash_and_pass();
        test_reset_mid_dying();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
